// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: fetch FSM encoding, reset vector,
// sequential PC step and the redirect-target result type.
package riscv_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_REQ   = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_ISSUE = 3'd4;
  localparam logic [2:0] ST_HALT  = 3'd5;

  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_INCR              = 32'd4;

  typedef struct packed {
    logic [31:0] target;
    logic        misaligned;
  } target_t;

  function automatic logic [31:0] next_seq_pc(input logic [31:0] pc);
    return pc + PC_INCR;
  endfunction

  function automatic logic is_misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/branch_target_calc.sv
// Combinational redirect-target generator for JAL/branch (PC-relative)
// and JALR (register-relative, bit 0 cleared); all sums wrap modulo 2^32.
module branch_target_calc
  import riscv_pkg::*;
(
  input  logic        pc_rel,
  input  logic [31:0] base_pc,
  input  logic [31:0] imm,
  input  logic [31:0] rs1,
  output target_t     result
);

  logic [31:0] sum;

  always_comb begin
    if (pc_rel) begin
      sum = base_pc + imm;
    end else begin
      sum = (rs1 + imm) & ~32'h0000_0001;
    end
    result.target     = sum;
    result.misaligned = is_misaligned(sum);
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Single-outstanding instruction fetch unit with redirect handling and a
// sticky misaligned-target halt.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | one cycle after reset release; memory responses ignored
// REQ      | issue read request at pc
// WAIT     | waiting for the read response
// DRAIN    | redirected while a request was in flight; discard response
// ISSUE    | instruction presented to decode
// HALT     | misaligned target seen; frozen until reset
module instr_fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instruction,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  input  logic        redirect_valid,
  input  logic        redirect_pc_rel,
  input  logic [31:0] redirect_imm,
  input  logic [31:0] redirect_rs1,
  output logic        misalign_err,
  output logic [31:0] instr_count
);

  logic [2:0]  state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic        load_instr;
  logic        set_err;
  logic        accept;
  logic        redir_take;
  logic        redir_ok;
  logic        redir_bad;
  target_t     tgt;

  branch_target_calc u_target (
    .pc_rel  (redirect_pc_rel),
    .base_pc (instr_pc),
    .imm     (redirect_imm),
    .rs1     (redirect_rs1),
    .result  (tgt)
  );

  assign redir_take = redirect_valid && (state != ST_HALT);
  assign redir_ok   = redir_take && !tgt.misaligned;
  assign redir_bad  = redir_take && tgt.misaligned;

  assign imem_req    = (state == ST_REQ);
  assign imem_addr   = imem_req ? pc : 32'h0000_0000;
  assign instr_valid = (state == ST_ISSUE);

  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    load_instr = 1'b0;
    set_err    = 1'b0;
    accept     = 1'b0;
    if (redir_bad) begin
      // pc is deliberately left pointing at the last good address
      state_nxt = ST_HALT;
      set_err   = 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          state_nxt = ST_REQ;
          if (redir_ok) pc_nxt = tgt.target;
        end
        ST_REQ: begin
          // a redirect here still owes us the response to this cycle's request
          if (redir_ok) begin
            pc_nxt    = tgt.target;
            state_nxt = ST_DRAIN;
          end else begin
            state_nxt = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (redir_ok) begin
            pc_nxt    = tgt.target;
            state_nxt = imem_rvalid ? ST_REQ : ST_DRAIN;
          end else if (imem_rvalid) begin
            load_instr = 1'b1;
            state_nxt  = ST_ISSUE;
          end
        end
        ST_DRAIN: begin
          if (redir_ok) pc_nxt = tgt.target;
          if (imem_rvalid) state_nxt = ST_REQ;
        end
        ST_ISSUE: begin
          if (redir_ok) begin
            pc_nxt    = tgt.target;
            state_nxt = ST_REQ;
          end else if (instr_ready) begin
            pc_nxt    = next_seq_pc(pc);
            accept    = 1'b1;
            state_nxt = ST_REQ;
          end
        end
        ST_HALT: state_nxt = ST_HALT;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      pc           <= RESET_VECTOR;
      instruction  <= 32'h0000_0000;
      instr_pc     <= 32'h0000_0000;
      misalign_err <= 1'b0;
      instr_count  <= 32'h0000_0000;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      if (load_instr) begin
        instruction <= imem_rdata;
        instr_pc    <= pc;
      end
      if (set_err) misalign_err <= 1'b1;
      if (accept) instr_count <= instr_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a variable-latency memory responder,
// an address/count/instruction model checked every cycle, and literal checks.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instruction;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        redirect_valid;
  logic        redirect_pc_rel;
  logic [31:0] redirect_imm;
  logic [31:0] redirect_rs1;
  logic        misalign_err;
  logic [31:0] instr_count;

  int n_chk  = 0;
  int n_pass = 0;

  int          mem_lat  = 1;
  int          mem_cd   = 0;
  logic [31:0] mem_addr = 32'h0;
  logic [31:0] req_log[$];

  logic [31:0] m_pc       = 32'h0;
  logic [31:0] m_last_req = 32'h0;
  logic [31:0] m_ipc      = 32'h0;
  logic [31:0] m_count    = 32'h0;
  logic [31:0] m_tgt      = 32'h0;
  logic        m_err      = 1'b0;
  logic        m_halt     = 1'b0;
  logic        m_prev_acc = 1'b0;

  always #5 clk = ~clk;

  instr_fetch_unit #(.RESET_VECTOR(32'h0000_0000)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_rvalid     (imem_rvalid),
    .imem_rdata      (imem_rdata),
    .instr_valid     (instr_valid),
    .instruction     (instruction),
    .instr_pc        (instr_pc),
    .instr_ready     (instr_ready),
    .redirect_valid  (redirect_valid),
    .redirect_pc_rel (redirect_pc_rel),
    .redirect_imm    (redirect_imm),
    .redirect_rs1    (redirect_rs1),
    .misalign_err    (misalign_err),
    .instr_count     (instr_count)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0070_0013;
    return {a[15:0], 16'h0013} ^ 32'h0500_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic timeout_fail(input string name);
    n_chk++;
    $display("FAIL %s: no DUT response within cycle budget at %0t", name, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(); step(); step();
    rst_n = 1'b1;
  endtask

  task automatic redirect(input logic rel, input logic [31:0] rs1, input logic [31:0] imm,
                          input logic rdy);
    redirect_valid  = 1'b1;
    redirect_pc_rel = rel;
    redirect_rs1    = rs1;
    redirect_imm    = imm;
    instr_ready     = rdy;
    step();
    redirect_valid  = 1'b0;
    instr_ready     = 1'b0;
  endtask

  task automatic wait_req(output logic [31:0] a);
    int budget = 0;
    a = 32'hFFFF_FFFF;
    while (!imem_req && budget < 100) begin
      step();
      budget++;
    end
    if (imem_req) a = imem_addr;
    else timeout_fail("wait_req");
  endtask

  task automatic wait_valid();
    int budget = 0;
    while (!instr_valid && budget < 100) begin
      step();
      budget++;
    end
    if (!instr_valid) timeout_fail("wait_valid");
  endtask

  task automatic run_accepts(input int n);
    int got = 0;
    int budget = 0;
    instr_ready = 1'b1;
    while (got < n && budget < 300) begin
      if (instr_valid) got++;
      step();
      budget++;
    end
    instr_ready = 1'b0;
    if (got < n) timeout_fail("run_accepts");
  endtask

  // Memory: one response mem_lat cycles after each request.
  initial begin
    imem_rvalid = 1'b0;
    imem_rdata  = 32'hDEAD_BEEF;
    forever begin
      @(posedge clk);
      #2;
      imem_rvalid = 1'b0;
      imem_rdata  = 32'hDEAD_BEEF;
      if (mem_cd > 0) begin
        mem_cd--;
        if (mem_cd == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem_word(mem_addr);
        end
      end
      if (imem_req) begin
        chk("one_outstanding", 32'(mem_cd), 32'h0);
        mem_addr = imem_addr;
        mem_cd   = mem_lat;
      end
    end
  end

  // Model and per-cycle compare.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_imem_req", {31'h0, imem_req}, 32'h0);
        chk("rst_imem_addr", imem_addr, 32'h0);
        chk("rst_instr_valid", {31'h0, instr_valid}, 32'h0);
        chk("rst_instruction", instruction, 32'h0);
        chk("rst_instr_pc", instr_pc, 32'h0);
        chk("rst_misalign", {31'h0, misalign_err}, 32'h0);
        chk("rst_count", instr_count, 32'h0);
        m_pc = 32'h0; m_last_req = 32'h0; m_ipc = 32'h0; m_count = 32'h0;
        m_err = 1'b0; m_halt = 1'b0; m_prev_acc = 1'b0;
      end else begin
        chk("misalign_err", {31'h0, misalign_err}, {31'h0, m_err});
        chk("instr_count", instr_count, m_count);
        if (m_halt) begin
          chk("halt_req", {31'h0, imem_req}, 32'h0);
          chk("halt_valid", {31'h0, instr_valid}, 32'h0);
        end
        if (imem_req) begin
          chk("fetch_addr", imem_addr, m_pc);
          req_log.push_back(imem_addr);
          m_last_req = imem_addr;
        end
        if (instr_valid) begin
          chk("instr_word", instruction, mem_word(m_last_req));
          chk("instr_pc", instr_pc, m_last_req);
          m_ipc = m_last_req;
        end
        if (m_prev_acc) chk("valid_drop", {31'h0, instr_valid}, 32'h0);
        m_prev_acc = 1'b0;
        if (!m_halt && redirect_valid) begin
          m_tgt = redirect_pc_rel ? m_ipc + redirect_imm
                                  : (redirect_rs1 + redirect_imm) & 32'hFFFF_FFFE;
          if (m_tgt[1:0] != 2'b00) begin
            m_halt = 1'b1;
            m_err  = 1'b1;
          end else begin
            m_pc = m_tgt;
          end
        end else if (!m_halt && instr_valid && instr_ready) begin
          m_pc       = m_pc + 32'd4;
          m_count    = m_count + 32'd1;
          m_prev_acc = 1'b1;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    int seen;
    rst_n = 1'b1; instr_ready = 1'b0; redirect_valid = 1'b0;
    redirect_pc_rel = 1'b0; redirect_imm = 32'h0; redirect_rs1 = 32'h0;
    #1 rst_n = 1'b0;

    // first fetch timing with single-cycle memory
    mem_lat = 1;
    do_reset();
    chk("c1_idle_no_req", {31'h0, imem_req}, 32'h0);
    step();
    chk("c2_req", {31'h0, imem_req}, 32'h1);
    chk("c2_addr", imem_addr, 32'h0);
    step();
    chk("c3_not_valid", {31'h0, instr_valid}, 32'h0);
    step();
    chk("c4_valid", {31'h0, instr_valid}, 32'h1);
    chk("c4_instr", instruction, 32'h0070_0013);
    chk("c4_pc", instr_pc, 32'h0);
    step(); step();
    chk("hold_valid", {31'h0, instr_valid}, 32'h1);
    chk("hold_instr", instruction, 32'h0070_0013);
    run_accepts(1);
    chk("valid_low_after_accept", {31'h0, instr_valid}, 32'h0);
    chk("count_one", instr_count, 32'h1);

    // four sequential accepts with latency 3
    mem_lat = 3;
    do_reset();
    req_log.delete();
    run_accepts(4);
    chk("seq_count", instr_count, 32'h4);
    for (int i = 0; i < 4; i++) begin
      a = (i < req_log.size()) ? req_log[i] : 32'hFFFF_FFFF;
      chk("seq_addr", a, 32'(4 * i));
    end

    // PC-relative redirect in ISSUE beats instr_ready
    mem_lat = 1;
    do_reset();
    run_accepts(2);
    wait_valid();
    chk("issue_pc_8", instr_pc, 32'h8);
    redirect(1'b1, 32'h0, 32'd16, 1'b1);
    chk("redir_no_count", instr_count, 32'h2);
    wait_req(a);
    chk("rel_target", a, 32'h18);

    // JALR redirect in WAIT drops the in-flight response
    wait_valid();
    mem_lat = 3;
    run_accepts(1);
    wait_req(a);
    step();
    redirect(1'b0, 32'h100, 32'd2048, 1'b0);
    wait_req(a);
    chk("jalr_target", a, 32'h900);
    wait_valid();
    chk("post_drain_pc", instr_pc, 32'h900);
    chk("post_drain_instr", instruction, mem_word(32'h900));

    // redirect in WAIT with same-cycle response: straight back to REQ
    mem_lat = 1;
    run_accepts(1);
    step();
    redirect(1'b0, 32'h201, 32'h0, 1'b0);
    chk("same_cycle_req", {31'h0, imem_req}, 32'h1);
    chk("jalr_bit0_clear", imem_addr, 32'h200);
    // redirect in REQ with wrapping sum, response drained
    redirect(1'b0, 32'hFFFF_FFF0, 32'h20, 1'b0);
    wait_req(a);
    chk("wrap_target", a, 32'h10);
    wait_valid();
    redirect(1'b1, 32'h0, 32'hFFFF_FFEC, 1'b1);
    chk("neg_imm_no_count", instr_count, 32'h4);
    wait_req(a);
    chk("neg_imm_target", a, 32'hFFFF_FFFC);
    wait_valid();
    run_accepts(1);
    wait_req(a);
    chk("pc_wrap", a, 32'h0);
    chk("count_five", instr_count, 32'h5);

    // misaligned target halts until reset
    wait_valid();
    redirect(1'b1, 32'h0, 32'h2, 1'b0);
    chk("misalign_set", {31'h0, misalign_err}, 32'h1);
    chk("halt_no_req", {31'h0, imem_req}, 32'h0);
    redirect(1'b0, 32'h80, 32'h0, 1'b1);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (imem_req || instr_valid) seen++;
      step();
    end
    chk("halt_quiet", 32'(seen), 32'h0);
    chk("misalign_sticky", {31'h0, misalign_err}, 32'h1);

    // redirect in IDLE, then reset mid-WAIT with late response
    mem_lat = 3;
    do_reset();
    redirect(1'b0, 32'h40, 32'h0, 1'b0);
    chk("idle_redir_req", {31'h0, imem_req}, 32'h1);
    chk("idle_redir_addr", imem_addr, 32'h40);
    step();
    rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();
    chk("refetch_req", {31'h0, imem_req}, 32'h1);
    chk("refetch_addr", imem_addr, 32'h0);
    wait_valid();
    chk("refetch_instr", instruction, 32'h0070_0013);
    chk("refetch_pc", instr_pc, 32'h0);
    run_accepts(1);
    chk("refetch_count", instr_count, 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter RESET_VECTOR, default 32'h0000_0000, SHALL give the PC loaded on reset.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 imem_req  output  1  one-cycle instruction-memory read request.
REQ-005 imem_addr  output  32  word-aligned read address; valid while imem_req=1.
REQ-006 imem_rvalid  input  1  read data valid, at least 1 cycle after imem_req.
REQ-007 imem_rdata  input  32  instruction word; valid while imem_rvalid=1.
REQ-008 instr_valid  output  1  instruction presented to decode/immediate generation.
REQ-009 instruction  output  32  fetched word; stable while instr_valid=1.
REQ-010 instr_pc  output  32  address of instruction.
REQ-011 instr_ready  input  1  decode accepts instruction.
REQ-012 redirect_valid  input  1  control-flow change from branch/jump resolution.
REQ-013 redirect_pc_rel  input  1  1: target = instr_pc + redirect_imm (JAL/SB); 0: target = (redirect_rs1 + redirect_imm) with bit 0 cleared (JALR).
REQ-014 redirect_imm  input  32  sign-extended immediate as produced by the immediate generator.
REQ-015 redirect_rs1  input  32  register base for JALR.
REQ-016 misalign_err  output  1  sticky fetch-target-misaligned flag.
REQ-017 instr_count  output  32  count of instructions accepted by decode.

Function
REQ-018 FSM states SHALL be IDLE, REQ, WAIT, DRAIN, ISSUE, HALT.
REQ-019 IDLE: lasts exactly one cycle after reset release, then REQ.
REQ-020 REQ: imem_req=1, imem_addr=pc for one cycle, then WAIT.
REQ-021 WAIT: on imem_rvalid, instruction<=imem_rdata, instr_pc<=pc, next ISSUE.
REQ-022 ISSUE: instr_valid=1; on instr_ready with no redirect, pc<=pc+4 (mod 2^32), instr_count+=1 (wraps at 2^32), next REQ; instr_valid SHALL be 0 in the next cycle.
REQ-023 Minimum fetch-to-issue latency SHALL be 2 cycles after the REQ cycle with 1-cycle memory.
REQ-024 Redirect target SHALL be 32-bit modulo sum; overflow ignored.
REQ-025 redirect_valid in ISSUE SHALL take priority over instr_ready: pc<=target, no count increment, next REQ.
REQ-026 redirect_valid in WAIT without imem_rvalid: pc<=target, next DRAIN; same-cycle rvalid: data discarded, pc<=target, next REQ.
REQ-027 DRAIN: discard the next imem_rvalid response, then REQ; further redirects in DRAIN overwrite pc.
REQ-028 redirect_valid in IDLE or REQ: pc<=target, next REQ (a REQ-cycle request's response still drained via DRAIN).
REQ-029 Target with bits[1:0]!=0 SHALL set misalign_err, leave pc unchanged, and enter HALT.
REQ-030 HALT: no requests, instr_valid=0, held until reset.
REQ-031 At most one memory request SHALL be outstanding.

Reset
REQ-032 Reset SHALL force: state IDLE, pc=RESET_VECTOR, imem_req=0, imem_addr=0, instr_valid=0, instruction=0, instr_pc=0, misalign_err=0, instr_count=0.
REQ-033 Reset asserted mid-WAIT SHALL abandon the outstanding request; the late response SHALL be ignored because IDLE ignores imem_rvalid.

Structure
REQ-034 FSM state encoding, RESET_VECTOR default and PC increment (4) SHALL live in the shared riscv package.
REQ-035 Target computation SHALL be one combinational sub-module, branch_target_calc.

Verification
REQ-036 Reset, 1-cycle memory returning 32'h0070_0013 -> imem_addr 0x0 in cycle 2, instr_valid in cycle 4, instruction 32'h0070_0013, instr_pc 0x0.
REQ-037 Four accepts with instr_ready=1, memory latency 3 -> addresses 0x0,0x4,0x8,0xC; instr_count=4.
REQ-038 ISSUE at instr_pc 0x8, redirect_pc_rel=1, imm=16 -> next imem_addr 0x18, instr_count unchanged even with instr_ready=1.
REQ-039 Redirect in WAIT (pc_rel=0, rs1 0x100, imm 2048) -> stale response dropped, next imem_addr 0x900.
REQ-040 Redirect pc_rel=1 imm=2 -> misalign_err=1, HALT, no further imem_req until rst_n low.
REQ-041 rst_n low during WAIT, response arrives during reset/IDLE -> ignored; first fetch from RESET_VECTOR.
